// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS datapath: next-PC selection,
// syscall halt/resume FSM and saturating run-statistics counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beq,
  input  logic                 bne,
  input  logic                 bgez,
  input  logic                 jmp,
  input  logic                 jr,
  input  logic                 jal,
  input  logic                 syscall,
  input  logic                 alu_equal,
  input  logic [31:0]          rs_data,
  input  logic [31:0]          v0_data,
  input  logic [15:0]          imm16,
  input  logic [25:0]          instr_index,
  input  logic                 go,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] jump_cnt,
  output logic [CNT_WIDTH-1:0] branch_cnt
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q;
  logic [31:0]          pc_q;
  logic                 go_q;
  logic [CNT_WIDTH-1:0] cycle_cnt_q;
  logic [CNT_WIDTH-1:0] jump_cnt_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_d;
  logic        take_br;
  logic        go_rise;
  logic        halt_req;

  // JAL only differs from J in the link write, which lives outside this block.
  logic unused_jal;
  assign unused_jal = jal;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_plus4[31:28], instr_index, 2'b00};
  assign take_br   = (beq & alu_equal) | (bne & ~alu_equal) | (bgez & ~rs_data[31]);
  assign go_rise   = go & ~go_q;
  assign halt_req  = syscall & (v0_data == HALT_CODE);

  // NOTE: every output-side signal here is a continuous assign, so no path
  // through this logic can leave a variable unassigned and infer a latch.
  assign pc_d = jr      ? rs_data   :
                jmp     ? j_target  :
                take_br ? br_target :
                          pc_plus4;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      go_q         <= 1'b0;
      cycle_cnt_q  <= '0;
      jump_cnt_q   <= '0;
      branch_cnt_q <= '0;
    end else begin
      go_q <= go;
      unique case (state_q)
        S_RUN: begin
          cycle_cnt_q <= sat_inc(cycle_cnt_q);
          if (jmp)          jump_cnt_q   <= sat_inc(jump_cnt_q);
          else if (take_br) branch_cnt_q <= sat_inc(branch_cnt_q);
          // The halting syscall keeps its own address in pc until resume.
          if (halt_req) state_q <= S_HALT;
          else          pc_q    <= pc_d;
        end
        S_HALT: begin
          if (go_rise) begin
            state_q <= S_RUN;
            pc_q    <= pc_plus4;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);
  assign cycle_cnt  = cycle_cnt_q;
  assign jump_cnt   = jump_cnt_q;
  assign branch_cnt = branch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a cycle model pushes expected state into a
// scoreboard queue before each edge; values are popped and compared after the edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        beq, bne, bgez, jmp, jr, jal, syscall, alu_equal, go;
  logic [31:0] rs_data, v0_data;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] pc, pc_plus4;
  logic        halted;
  logic [31:0] cycle_cnt, jump_cnt, branch_cnt;

  logic        s_rst_n, s_jmp;
  logic [31:0] s_pc, s_pc_plus4;
  logic        s_halted;
  logic [3:0]  s_cycle_cnt, s_jump_cnt, s_branch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cyc;
    logic [31:0] jmp;
    logic [31:0] br;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_cyc, m_jmp, m_br;
  logic        m_halt, m_goq;

  pc_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .beq(beq), .bne(bne), .bgez(bgez), .jmp(jmp),
    .jr(jr), .jal(jal), .syscall(syscall), .alu_equal(alu_equal),
    .rs_data(rs_data), .v0_data(v0_data), .imm16(imm16), .instr_index(instr_index),
    .go(go), .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
    .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt), .branch_cnt(branch_cnt)
  );

  pc_sequencer #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(s_rst_n), .beq(1'b0), .bne(1'b0), .bgez(1'b0), .jmp(s_jmp),
    .jr(1'b0), .jal(1'b0), .syscall(1'b0), .alu_equal(1'b0),
    .rs_data(32'h0), .v0_data(32'h0), .imm16(16'h0), .instr_index(26'h0),
    .go(1'b0), .pc(s_pc), .pc_plus4(s_pc_plus4), .halted(s_halted),
    .cycle_cnt(s_cycle_cnt), .jump_cnt(s_jump_cnt), .branch_cnt(s_branch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    beq = 0; bne = 0; bgez = 0; jmp = 0; jr = 0; jal = 0; syscall = 0;
    alu_equal = 0; rs_data = 0; v0_data = 0; imm16 = 0; instr_index = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halt = 0; m_goq = 0; m_cyc = 0; m_jmp = 0; m_br = 0;
  endtask

  task automatic model_step();
    logic [31:0] p4, off;
    logic        tk;
    p4  = m_pc + 32'd4;
    off = {{16{imm16[15]}}, imm16};
    tk  = (beq && alu_equal) || (bne && !alu_equal) || (bgez && !rs_data[31]);
    if (!m_halt) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (jmp) begin
        if (m_jmp != 32'hFFFF_FFFF) m_jmp = m_jmp + 1;
      end else if (tk) begin
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      end
      if (syscall && v0_data == 32'd10) m_halt = 1;
      else if (jr)  m_pc = rs_data;
      else if (jmp) m_pc = {p4[31:28], instr_index, 2'b00};
      else if (tk)  m_pc = p4 + (off << 2);
      else          m_pc = p4;
    end else if (go && !m_goq) begin
      m_halt = 0;
      m_pc   = p4;
    end
    m_goq = go;
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    e = '{pc: m_pc, halted: m_halt, cyc: m_cyc, jmp: m_jmp, br: m_br};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc || pc_plus4 !== e.pc + 32'd4 || halted !== e.halted ||
        cycle_cnt !== e.cyc || jump_cnt !== e.jmp || branch_cnt !== e.br) begin
      errors++;
      $display("FAIL scoreboard t=%0t: pc=%h p4=%h h=%b cyc=%0d j=%0d b=%0d, expected pc=%h h=%b cyc=%0d j=%0d b=%0d",
               $time, pc, pc_plus4, halted, cycle_cnt, jump_cnt, branch_cnt,
               e.pc, e.halted, e.cyc, e.jmp, e.br);
    end
  endtask

  task automatic set_pc(input logic [31:0] target);
    idle_inputs(); jr = 1; jmp = 1; rs_data = target;
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); go = 0; rst_n = 0; s_rst_n = 0; s_jmp = 1;
    model_reset();
    #12;
    checks++;
    if (pc !== 32'h0 || halted !== 1'b0 || cycle_cnt !== 0 || jump_cnt !== 0 || branch_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state: pc=%h halted=%b cnt=%0d/%0d/%0d, expected 0/0/0/0/0",
               pc, halted, cycle_cnt, jump_cnt, branch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (pc !== 32'hC || cycle_cnt !== 32'd3 || jump_cnt !== 0 || branch_cnt !== 0) begin
      errors++;
      $display("FAIL reset_seq: pc=%h cyc=%0d j=%0d b=%0d, expected pc=0000000c cyc=3 j=0 b=0",
               pc, cycle_cnt, jump_cnt, branch_cnt);
    end
  endtask

  task automatic test_branches();
    logic [31:0] b0;
    set_pc(32'h10);
    b0 = branch_cnt;
    beq = 1; alu_equal = 1; imm16 = 16'hFFFC;
    cycle();
    checks++;
    if (pc !== 32'h4 || branch_cnt !== b0 + 1) begin
      errors++;
      $display("FAIL beq_taken: pc=%h br=%0d, expected pc=00000004 br=%0d", pc, branch_cnt, b0 + 1);
    end
    set_pc(32'h10);
    beq = 1; alu_equal = 0; imm16 = 16'hFFFC;
    cycle();
    checks++;
    if (pc !== 32'h14 || branch_cnt !== b0 + 1) begin
      errors++;
      $display("FAIL beq_not_taken: pc=%h br=%0d, expected pc=00000014 br=%0d", pc, branch_cnt, b0 + 1);
    end
    idle_inputs(); bgez = 1; rs_data = 32'h8000_0000; imm16 = 16'h0010;
    cycle();
    checks++;
    if (pc !== 32'h18 || branch_cnt !== b0 + 1) begin
      errors++;
      $display("FAIL bgez_neg: pc=%h br=%0d, expected pc=00000018 br=%0d", pc, branch_cnt, b0 + 1);
    end
    idle_inputs(); bgez = 1; rs_data = 32'h0000_0005; imm16 = 16'h0010;
    cycle();
    idle_inputs(); bne = 1; alu_equal = 0; imm16 = 16'h0002;
    cycle();
    checks++;
    if (pc !== 32'h68 || branch_cnt !== b0 + 3) begin
      errors++;
      $display("FAIL bgez_bne_taken: pc=%h br=%0d, expected pc=00000068 br=%0d", pc, branch_cnt, b0 + 3);
    end
    idle_inputs();
  endtask

  task automatic test_jumps();
    logic [31:0] j0, b0;
    set_pc(32'h3000_0040);
    j0 = jump_cnt;
    jmp = 1; instr_index = 26'h100;
    cycle();
    checks++;
    if (pc !== 32'h3000_0400 || jump_cnt !== j0 + 1) begin
      errors++;
      $display("FAIL j_target: pc=%h j=%0d, expected pc=30000400 j=%0d", pc, jump_cnt, j0 + 1);
    end
    b0 = branch_cnt;
    idle_inputs(); jr = 1; jmp = 1; jal = 1; rs_data = 32'h0000_1234;
    beq = 1; alu_equal = 1; imm16 = 16'h0040; instr_index = 26'h3FF_FFFF;
    cycle();
    checks++;
    if (pc !== 32'h1234 || jump_cnt !== j0 + 2 || branch_cnt !== b0) begin
      errors++;
      $display("FAIL jr_priority: pc=%h j=%0d b=%0d, expected pc=00001234 j=%0d b=%0d",
               pc, jump_cnt, branch_cnt, j0 + 2, b0);
    end
    idle_inputs();
  endtask

  task automatic test_halt_resume();
    logic [31:0] c0;
    set_pc(32'h20);
    go = 1;
    syscall = 1; v0_data = 32'd10;
    cycle();
    c0 = cycle_cnt;
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); jmp = 1; beq = 1; alu_equal = 1; instr_index = 26'h55;
      cycle();
    end
    checks++;
    if (halted !== 1'b1 || pc !== 32'h20 || cycle_cnt !== c0) begin
      errors++;
      $display("FAIL halt_hold: halted=%b pc=%h cyc=%0d, expected halted=1 pc=00000020 cyc=%0d",
               halted, pc, cycle_cnt, c0);
    end
    idle_inputs();
    go = 0;
    cycle();
    go = 1;
    cycle();
    checks++;
    if (halted !== 1'b0 || pc !== 32'h24 || cycle_cnt !== c0) begin
      errors++;
      $display("FAIL resume: halted=%b pc=%h cyc=%0d, expected halted=0 pc=00000024 cyc=%0d",
               halted, pc, cycle_cnt, c0);
    end
    go = 0;
    syscall = 1; v0_data = 32'd1;
    cycle();
    checks++;
    if (halted !== 1'b0 || pc !== 32'h28) begin
      errors++;
      $display("FAIL syscall_noop: halted=%b pc=%h, expected halted=0 pc=00000028", halted, pc);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_halt();
    syscall = 1; v0_data = 32'd10;
    cycle();
    idle_inputs();
    cycle();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (halted !== 1'b0 || pc !== 32'h0 || cycle_cnt !== 0 || jump_cnt !== 0 || branch_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_halt: halted=%b pc=%h cnt=%0d/%0d/%0d, expected all zero",
               halted, pc, cycle_cnt, jump_cnt, branch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    cycle();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h, expected 00000000", pc);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      beq = 1'($urandom); bne = 1'($urandom); bgez = 1'($urandom);
      jmp = ($urandom_range(0, 3) == 0); jr = ($urandom_range(0, 4) == 0);
      jal = 1'($urandom); alu_equal = 1'($urandom);
      syscall = ($urandom_range(0, 7) == 0);
      v0_data = ($urandom_range(0, 1) == 0) ? 32'd10 : 32'($urandom_range(0, 20));
      rs_data = $urandom; imm16 = 16'($urandom); instr_index = 26'($urandom);
      go = 1'($urandom);
      cycle();
    end
    idle_inputs(); go = 0;
    cycle();
    go = 1;
    cycle();
    go = 0;
  endtask

  task automatic test_saturation();
    idle_inputs();
    s_rst_n = 0;
    #1;
    s_rst_n = 1;
    for (int i = 0; i < 14; i++) cycle();
    checks++;
    if (s_cycle_cnt !== 4'd14 || s_jump_cnt !== 4'd14 || s_branch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_count: cyc=%0d j=%0d b=%0d, expected 14/14/0", s_cycle_cnt, s_jump_cnt, s_branch_cnt);
    end
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (s_cycle_cnt !== 4'hF || s_jump_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold: cyc=%0d j=%0d, expected 15/15", s_cycle_cnt, s_jump_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_branches();
    test_jumps();
    test_halt_resume();
    test_reset_mid_halt();
    test_wrap();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
